// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
// Drains a FIFO one DATA_BITS-wide word at a time. Each word is sent as an
// asynchronous UART frame on tx_o: a start bit, the data bits LSB first,
// then STOP_BITS stop bits. The block pops the FIFO only while idle, so
// frames go out back-to-back with exactly one idle cycle between them.
// All outputs are registered, and each output reflects the previous cycle's
// FSM state.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bits.
module uart_tx_fifo_drain #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 empty_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 read_o,
   output logic                 tx_o,
   output logic                 busy_o
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [TW-1:0]         tick_q;
   logic [TW-1:0]         tick_d;
   logic [BW-1:0]         bit_q;
   logic [BW-1:0]         bit_d;
   logic [DATA_BITS-1:0]  shift_q;
   logic [DATA_BITS-1:0]  shift_d;
   logic                  read_d;
   logic                  tx_d;
   logic                  busy_d;
   logic                  tick_last;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q;
   logic                  parity_d;
`endif

   assign tick_last = (tick_q == TICK_LAST);

   // Next-state logic: the FIFO is sampled in IDLE only, and each serial
   // state holds for whole bit periods. The bit counter also counts stop bits.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      read_d   = 1'b0;
      tx_d     = 1'b1;
      busy_d   = (state_q != S_IDLE);
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty_i) begin
               shift_d  = data_i;
               read_d   = 1'b1;
               tick_d   = '0;
               bit_d    = '0;
               state_d  = S_START;
`ifdef UART_TX_PARITY_EN
               parity_d = ^data_i;
`endif
            end
         end

         S_START: begin
            tx_d = 1'b0;
            if (tick_last) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end

         S_DATA: begin
            tx_d = shift_q[0];
            if (tick_last) begin
               shift_d = shift_q >> 1;
               tick_d  = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            tx_d = parity_q;
            if (tick_last) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = S_STOP;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
`endif

         S_STOP: begin
            tx_d = 1'b1;
            if (tick_last) begin
               tick_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end

         default: begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters, shift register and registered outputs; reset forces the line idle at once
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         read_o   <= 1'b0;
         tx_o     <= 1'b1;
         busy_o   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         read_o   <= read_d;
         tx_o     <= tx_d;
         busy_o   <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain
// Randomised FIFO traffic against a cycle-level waveform model. Each pop
// queues the whole expected tx_o frame, and the queue is consumed one entry
// per clock. A pop is expected only when the previous frame has fully
// drained before the current edge.
module tb_uart_tx_fifo_drain;

   localparam int CPB = 4;
   localparam int DB  = 8;
   localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PB        = 1;
   localparam int LIT_FRAME = 44;
   localparam int LIT_GAP   = 45;
`else
   localparam int PB        = 0;
   localparam int LIT_FRAME = 40;
   localparam int LIT_GAP   = 41;
`endif
   localparam int FRAME = (1 + DB + PB + SB) * CPB;

   typedef logic bitq_t[$];

   logic          clk_i   = 1'b0;
   logic          reset_i = 1'b0;
   logic          empty_i = 1'b1;
   logic [DB-1:0] data_i  = '0;
   logic          read_o;
   logic          tx_o;
   logic          busy_o;

   int            errors = 0;
   int            checks = 0;
   int            cyc    = 0;

   logic [DB-1:0] fifo_q[$];
   bitq_t         exp_wave;
   logic          exp_tx;
   logic          exp_read;
   logic          exp_busy;

   int            read_count  = 0;
   int            last_read   = -1;
   int            gaps[$];
   int            busy_cycles = 0;

   uart_tx_fifo_drain #(
      .DATA_BITS   (DB),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (SB)
   ) dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .empty_i(empty_i),
      .data_i (data_i),
      .read_o (read_o),
      .tx_o   (tx_o),
      .busy_o (busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endfunction

   // One full frame as seen on the line, one entry per clock cycle
   function automatic bitq_t frame_of(input logic [DB-1:0] b);
      bitq_t q;
      for (int i = 0; i < CPB; i++) q.push_back(1'b0);
      for (int k = 0; k < DB; k++)
         for (int i = 0; i < CPB; i++) q.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
      for (int i = 0; i < CPB; i++) q.push_back(^b);
`endif
      for (int i = 0; i < SB * CPB; i++) q.push_back(1'b1);
      return q;
   endfunction

   task automatic drive_inputs(input bit glitch);
      if (glitch) begin
         empty_i = 1'b0;
         data_i  = DB'($urandom);
      end else if (fifo_q.size() > 0) begin
         empty_i = 1'b0;
         data_i  = fifo_q[0];
      end else begin
         empty_i = 1'b1;
         data_i  = DB'($urandom);
      end
   endtask

   task automatic push(input logic [DB-1:0] b);
      fifo_q.push_back(b);
      drive_inputs(1'b0);
   endtask

   // One clock: advance the model, compare all outputs, then drive the next inputs
   task automatic step(input bit glitch);
      bit was_idle;
      @(posedge clk_i);
      #1;
      cyc++;
      if (exp_wave.size() > 0) begin
         exp_tx   = exp_wave.pop_front();
         exp_busy = 1'b1;
         was_idle = 1'b0;
      end else begin
         exp_tx   = 1'b1;
         exp_busy = 1'b0;
         was_idle = 1'b1;
      end
      exp_read = was_idle && !reset_i && !empty_i;
      if (exp_read) begin
         exp_wave = frame_of(data_i);
         if (fifo_q.size() > 0) fifo_q.delete(0);
      end
      chk("read_o", {31'd0, read_o}, {31'd0, exp_read});
      chk("tx_o",   {31'd0, tx_o},   {31'd0, exp_tx});
      chk("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
      if (read_o) begin
         read_count++;
         if (last_read >= 0) gaps.push_back(cyc - last_read);
         last_read = cyc;
      end
      if (busy_o) busy_cycles++;
      drive_inputs(glitch);
   endtask

   task automatic wait_read();
      int n = 0;
      while (!read_o && n < 50) begin
         step(1'b0);
         n++;
      end
      chk("read_wait", {31'd0, read_o}, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog at cycle %0d: got timeout, expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bitq_t      pin;
      logic [9:0] a5_lit;
      int         n;

      // Asynchronous reset before any clock edge
      #2 reset_i = 1'b1;
      #1;
      chk("reset_tx",   {31'd0, tx_o},   32'd1);
      chk("reset_read", {31'd0, read_o}, 32'd0);
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      repeat (2) @(posedge clk_i);
      #2 reset_i = 1'b0;

      // Hand-computed frame for 0xA5: start, 1,0,1,0,0,1,0,1, stop
      a5_lit = 10'b1101001010;
      pin = frame_of(8'hA5);
      chk("pin_a5_len", pin.size(), LIT_FRAME);
      for (int k = 0; k < 9; k++)
         chk("pin_a5_bit", {31'd0, pin[k*CPB + CPB/2]}, {31'd0, a5_lit[k]});
      chk("pin_a5_stop", {31'd0, pin[pin.size()-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
      pin = frame_of(8'h07);
      chk("pin_par_07", {31'd0, pin[DB*CPB + CPB + 1]}, 32'd1);
      pin = frame_of(8'h03);
      chk("pin_par_03", {31'd0, pin[DB*CPB + CPB + 1]}, 32'd0);
`endif

      // Empty FIFO: line stays idle
      repeat (100) step(1'b0);
      chk("idle_reads", read_count, 0);
      chk("idle_busy",  busy_cycles, 0);

      // Single byte
      read_count  = 0;
      busy_cycles = 0;
      push(8'hA5);
      repeat (FRAME + 20) step(1'b0);
      chk("a5_reads",    read_count, 1);
      chk("a5_busy_len", busy_cycles, LIT_FRAME);

      // Back-to-back bytes
      read_count = 0;
      last_read  = -1;
      gaps.delete();
      push(8'h3C);
      push(8'hFF);
      push(8'h00);
      repeat (3 * (FRAME + 1) + 20) step(1'b0);
      chk("b2b_reads", read_count, 3);
      chk("b2b_ngaps", gaps.size(), 2);
      for (int i = 0; i < gaps.size(); i++) chk("b2b_gap", gaps[i], LIT_GAP);

      // Reset 13 cycles into a frame
      read_count = 0;
      push(8'h55);
      wait_read();
      repeat (12) step(1'b0);
      #3 reset_i = 1'b1;
      #1;
      chk("midrst_tx",   {31'd0, tx_o},   32'd1);
      chk("midrst_busy", {31'd0, busy_o}, 32'd0);
      chk("midrst_read", {31'd0, read_o}, 32'd0);
      exp_wave.delete();
      repeat (3) step(1'b0);
      #2 reset_i = 1'b0;
      repeat (60) step(1'b0);
      chk("midrst_reads", read_count, 1);

      // One-cycle empty_i glitch in the middle of the data bits
      read_count = 0;
      push(8'h96);
      wait_read();
      repeat (7) step(1'b0);
      step(1'b1);
      repeat (FRAME + 20) step(1'b0);
      chk("glitch_reads", read_count, 1);

      // Parity-relevant bytes
      read_count = 0;
      push(8'h07);
      repeat (FRAME + 10) step(1'b0);
      push(8'h03);
      repeat (FRAME + 10) step(1'b0);
      chk("par_reads", read_count, 2);

      // Random bursts, including writes during frames
      for (int it = 0; it < 25; it++) begin
         n = $urandom_range(0, 3);
         for (int j = 0; j < n; j++) push(DB'($urandom));
         repeat ($urandom_range(1, 60)) step(1'b0);
      end
      repeat ((fifo_q.size() + 1) * (FRAME + 1) + 10) step(1'b0);
      chk("drained", fifo_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
